sensor_frame_sequencer: RTL and testbench
=========================================

Name: sensor_frame_sequencer

Overview:
- Parametrised successor to the pixel-array state controller.
- Sequences one full exposure frame per start request: ERASE, EXPOSE, CONVERT (digital ramp), then READ (row scan).
- Adds a start/busy/frame_done handshake, a runtime exposure length, continuous (free-running) mode and synchronous abort.
- Sits between the top-level camera control and the pixel array / readout path.

Parameters:
- ROWS, 2, number of pixel rows; width of p_row_select.
- ADC_BITS, 8, digital ramp width; CONVERT lasts 2^ADC_BITS cycles.
- ERASE_CYCLES, 5, ERASE duration in cycles (>=1).
- ROW_READ_CYCLES, 5, cycles each row stays selected (>=1).
- EXPOSE_W, 10, width of the expose_cycles input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; highest priority.
- start  in  1  frame request, sampled only in IDLE.
- continuous  in  1  free-run mode, latched with start.
- abort  in  1  synchronous abort to IDLE.
- expose_cycles  in  EXPOSE_W  exposure length, latched with start.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at completion of each frame.
- p_erase  out  1  high throughout ERASE.
- p_expose  out  1  high throughout EXPOSE.
- p_convert  out  1  high throughout CONVERT; analog ramp enable.
- p_dRamp  out  ADC_BITS  digital ramp value.
- p_row_select  out  ROWS  one-hot row select during READ, else 0.
- new_row  out  1  one-cycle pulse on the first cycle of each row window.

Behaviour:
- States: IDLE, ERASE, EXPOSE, CONVERT, READ. All outputs are registered.
- Reset: state=IDLE, counters=0, all outputs 0. Reset overrides start and abort.
- IDLE: start=1 at edge N moves to ERASE from cycle N+1.
  - expose_cycles and continuous are latched at edge N.
  - A latched exposure value of 0 is treated as 1.
- ERASE: exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: exactly the latched exposure count of cycles, then CONVERT.
- CONVERT: exactly 2^ADC_BITS cycles.
  - p_dRamp=0 in the first cycle and increments by 1 per cycle, reaching all-ones in the last cycle.
  - p_dRamp=0 in every other state; no wrap is visible.
- READ: ROWS*ROW_READ_CYCLES cycles.
  - Row r (LSB = row 0) is selected for cycles r*ROW_READ_CYCLES through (r+1)*ROW_READ_CYCLES-1.
  - new_row=1 on the first cycle of each window, including row 0.
- End of READ: frame_done=1 for exactly one cycle, the first cycle after the last READ cycle.
  - If latched continuous=0, that cycle is IDLE and busy=0.
  - If latched continuous=1, that cycle is ERASE of the next frame; expose_cycles and continuous are re-latched at the final READ edge; busy stays 1.
- start while busy: ignored; no queueing.
- abort=1 in any non-IDLE state: IDLE on the next cycle, all outputs 0, no frame_done.
  - abort in IDLE: no effect.
  - abort and start together in IDLE: abort wins and the block stays IDLE.
- Phase counter width: $clog2 of the maximum of ERASE_CYCLES, 2^EXPOSE_W, 2^ADC_BITS and ROWS*ROW_READ_CYCLES. It clears on every state change.
- Exactly one of p_erase, p_expose, p_convert or a p_row_select bit is high in any busy cycle.
- No clock gating; p_convert replaces any clock-derived ramp signal.

Decomposition:
- Shared package sensor_seq_pkg:
  - state enum seq_state_t (IDLE, ERASE, EXPOSE, CONVERT, READ).
  - default timing constants, with ROWS and ADC_BITS defaults taken from the pixel sensor config package.
- Sub-module sensor_row_scanner: one-hot row shifter plus row-window counter.
  - Inputs: clk, reset, enable, clear.
  - Outputs: row_select, new_row.
  - Instantiated once for the READ phase.

Test Plan (defaults unless stated; expose_cycles=10; start pulsed at edge 0):
- Single frame, continuous=0 -> required response:
  - p_erase on cycles 1-5.
  - p_expose on cycles 6-15.
  - p_convert on cycles 16-271, with p_dRamp 0 at cycle 16 and 255 at cycle 271.
  - Row 0 selected on cycles 272-276 and row 1 on cycles 277-281.
  - new_row at cycles 272 and 277.
  - frame_done and busy=0 at cycle 282.
- expose_cycles=0 -> p_expose high for exactly 1 cycle (cycle 6); frame_done at cycle 273.
- continuous=1 -> frame_done at cycles 282 and 563; p_erase high at cycle 282; busy never drops.
  - Clearing continuous before the edge at cycle 281 ends the run after the second frame.
- abort at cycle 100 (CONVERT) -> IDLE at cycle 101, all outputs 0, no frame_done.
  - Next start runs a full frame with p_dRamp restarting at 0.
- start re-pulsed at cycle 50 while busy -> no effect; frame_done still only at cycle 282.
- reset at cycle 200 concurrent with abort and start -> all outputs 0 from cycle 201; block stays IDLE.
  - Sweep with ROWS=4, ROW_READ_CYCLES=3: new_row every 3 cycles during READ and one-hot order 0001→1000.

Source files
------------

// File: rtl/sensor_seq_pkg.sv
// Shared state encoding and default timing for the frame sequencer and its row scanner.
// Pixel-array geometry defaults mirror the sensor configuration.
package sensor_seq_pkg;

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} seq_state_t;

  localparam int PIX_ROWS            = 2;
  localparam int PIX_ADC_BITS        = 8;
  localparam int DEF_ERASE_CYCLES    = 5;
  localparam int DEF_ROW_READ_CYCLES = 5;
  localparam int DEF_EXPOSE_W        = 10;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sensor_row_scanner.sv
// One-hot row shifter for the READ phase; each row is held for ROW_READ_CYCLES cycles
// and new_row marks the first cycle of every window.
module sensor_row_scanner #(
  parameter int ROWS            = 2,
  parameter int ROW_READ_CYCLES = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  output logic [ROWS-1:0] row_select,
  output logic            new_row
);

  localparam int WW = (ROW_READ_CYCLES > 1) ? $clog2(ROW_READ_CYCLES) : 1;

  logic [WW-1:0] win_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row_select <= '0;
      new_row    <= 1'b0;
      win_cnt    <= '0;
    end else if (enable) begin
      // Empty select means this is the first READ cycle: start at row 0.
      if (row_select == '0) begin
        row_select <= ROWS'(1);
        new_row    <= 1'b1;
        win_cnt    <= '0;
      end else if (win_cnt == WW'(ROW_READ_CYCLES - 1)) begin
        row_select <= row_select << 1;
        new_row    <= 1'b1;
        win_cnt    <= '0;
      end else begin
        new_row    <= 1'b0;
        win_cnt    <= win_cnt + WW'(1);
      end
    end else begin
      new_row <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_frame_sequencer.sv
// Frame sequencer: ERASE -> EXPOSE -> CONVERT (digital ramp) -> READ per start request,
// with runtime exposure length, free-running mode and synchronous abort.
module sensor_frame_sequencer
  import sensor_seq_pkg::*;
#(
  parameter int ROWS            = PIX_ROWS,
  parameter int ADC_BITS        = PIX_ADC_BITS,
  parameter int ERASE_CYCLES    = DEF_ERASE_CYCLES,
  parameter int ROW_READ_CYCLES = DEF_ROW_READ_CYCLES,
  parameter int EXPOSE_W        = DEF_EXPOSE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [EXPOSE_W-1:0] expose_cycles,
  output logic                busy,
  output logic                frame_done,
  output logic                p_erase,
  output logic                p_expose,
  output logic                p_convert,
  output logic [ADC_BITS-1:0] p_dRamp,
  output logic [ROWS-1:0]     p_row_select,
  output logic                new_row
);

  localparam int READ_CYCLES = ROWS * ROW_READ_CYCLES;
  localparam int PW = $clog2(max4(ERASE_CYCLES, 2**EXPOSE_W, 2**ADC_BITS, READ_CYCLES));

  seq_state_t          state, state_n;
  logic [PW-1:0]       cnt, cnt_n;
  logic [EXPOSE_W-1:0] exp_last;
  logic                cont;
  logic                latch, done_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + PW'(1);
    latch   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = ERASE;
          latch   = 1'b1;
        end
      end
      ERASE:
        if (cnt == PW'(ERASE_CYCLES - 1)) begin
          state_n = EXPOSE;
          cnt_n   = '0;
        end
      EXPOSE:
        if (cnt == PW'(exp_last)) begin
          state_n = CONVERT;
          cnt_n   = '0;
        end
      CONVERT:
        if (cnt == PW'(2**ADC_BITS - 1)) begin
          state_n = READ;
          cnt_n   = '0;
        end
      READ:
        if (cnt == PW'(READ_CYCLES - 1)) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          // Free-run: the done cycle is already ERASE of the next frame.
          state_n = cont ? ERASE : IDLE;
          latch   = cont;
        end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Abort also blocks a coincident start in IDLE.
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      latch   = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      exp_last   <= '0;
      cont       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      p_erase    <= 1'b0;
      p_expose   <= 1'b0;
      p_convert  <= 1'b0;
      p_dRamp    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        // Stored as last-cycle index; a zero request still exposes one cycle.
        exp_last <= (expose_cycles == '0) ? '0 : expose_cycles - EXPOSE_W'(1);
        cont     <= continuous;
      end
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
      p_erase    <= (state_n == ERASE);
      p_expose   <= (state_n == EXPOSE);
      p_convert  <= (state_n == CONVERT);
      p_dRamp    <= (state_n == CONVERT) ? cnt_n[ADC_BITS-1:0] : '0;
    end
  end

  sensor_row_scanner #(
    .ROWS            (ROWS),
    .ROW_READ_CYCLES (ROW_READ_CYCLES)
  ) u_row_scanner (
    .clk        (clk),
    .reset      (reset),
    .enable     (state_n == READ),
    .clear      (state_n != READ),
    .row_select (p_row_select),
    .new_row    (new_row)
  );

endmodule

// File: tb/tb_sensor_frame_sequencer.sv
// Scoreboard bench: directed frames push hand-timed output snapshots per cycle; a negedge
// monitor pops and compares them, and flags any frame_done/new_row nobody expected.
module tb_sensor_frame_sequencer;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic       continuous = 1'b0, abort = 1'b0, abort2 = 1'b0;
  logic [9:0] expose_cycles = 10'd10;

  logic       busy, frame_done, p_erase, p_expose, p_convert, new_row;
  logic [7:0] p_dRamp;
  logic [1:0] p_row_select;
  logic       busy2, frame_done2, p_erase2, p_expose2, p_convert2, new_row2;
  logic [7:0] p_dRamp2;
  logic [3:0] p_row_select2;

  sensor_frame_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .expose_cycles(expose_cycles), .busy(busy), .frame_done(frame_done),
    .p_erase(p_erase), .p_expose(p_expose), .p_convert(p_convert), .p_dRamp(p_dRamp),
    .p_row_select(p_row_select), .new_row(new_row)
  );

  sensor_frame_sequencer #(.ROWS(4), .ROW_READ_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .continuous(continuous), .abort(abort2),
    .expose_cycles(expose_cycles), .busy(busy2), .frame_done(frame_done2),
    .p_erase(p_erase2), .p_expose(p_expose2), .p_convert(p_convert2), .p_dRamp(p_dRamp2),
    .p_row_select(p_row_select2), .new_row(new_row2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    int          cyc;
    logic [16:0] v;
    string       name;
  } exp_t;

  exp_t q0[$], q1[$];
  localparam logic [16:0] Z = '0;

  function automatic logic [16:0] S(input logic b, input logic fd, input logic er,
                                    input logic ex, input logic cv, input logic [7:0] ramp,
                                    input logic [3:0] rows, input logic nr);
    return {b, fd, er, ex, cv, ramp, rows, nr};
  endfunction

  task automatic push(input int d, input int c, input logic [16:0] v, input string name);
    exp_t e;
    int   i;
    e.cyc = c; e.v = v; e.name = name;
    i = 0;
    if (d == 0) begin
      while (i < q0.size() && q0[i].cyc <= c) i++;
      q0.insert(i, e);
    end else begin
      while (i < q1.size() && q1[i].cyc <= c) i++;
      q1.insert(i, e);
    end
  endtask

  task automatic mon(input int d, input logic [16:0] act, input logic ev);
    exp_t e;
    bit   seen;
    seen = 0;
    while (1) begin
      if (d == 0) begin
        if (q0.size() == 0 || q0[0].cyc > cyc) break;
        e = q0.pop_front();
      end else begin
        if (q1.size() == 0 || q1[0].cyc > cyc) break;
        e = q1.pop_front();
      end
      seen = 1;
      n_chk++;
      if (e.cyc != cyc || act !== e.v) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d: got %h expected %h (for cycle %0d)",
                 e.name, d, cyc, act, e.v, e.cyc);
      end
    end
    if (ev && !seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d cycle %0d: got %h expected no event", d, cyc, act);
    end
  endtask

  always @(negedge clk) begin
    mon(0, S(busy, frame_done, p_erase, p_expose, p_convert, p_dRamp, {2'b00, p_row_select}, new_row),
        frame_done | new_row);
    mon(1, S(busy2, frame_done2, p_erase2, p_expose2, p_convert2, p_dRamp2, p_row_select2, new_row2),
        frame_done2 | new_row2);
  end

  // Cycle k of a frame is sampled at the negedge where cyc == t0 + k.
  task automatic push_frame(input int d, input int t0, input int elen, input int rows,
                            input int rrc, input bit cont_next);
    int r0, dn;
    r0 = t0 + 6 + elen + 256;
    push(d, t0 + 2,        S(1, 0, 1, 0, 0, 8'd0, 4'd0, 0), "erase");
    push(d, t0 + 5,        S(1, 0, 1, 0, 0, 8'd0, 4'd0, 0), "erase_last");
    push(d, t0 + 6,        S(1, 0, 0, 1, 0, 8'd0, 4'd0, 0), "expose_first");
    push(d, t0 + 5 + elen, S(1, 0, 0, 1, 0, 8'd0, 4'd0, 0), "expose_last");
    push(d, t0 + 6 + elen, S(1, 0, 0, 0, 1, 8'd0, 4'd0, 0), "ramp_first");
    push(d, t0 + 7 + elen, S(1, 0, 0, 0, 1, 8'd1, 4'd0, 0), "ramp_step");
    push(d, r0 - 1,        S(1, 0, 0, 0, 1, 8'd255, 4'd0, 0), "ramp_last");
    for (int r = 0; r < rows; r++) begin
      push(d, r0 + r * rrc,           S(1, 0, 0, 0, 0, 8'd0, 4'(1 << r), 1), "row_start");
      push(d, r0 + r * rrc + rrc - 1, S(1, 0, 0, 0, 0, 8'd0, 4'(1 << r), 0), "row_end");
    end
    dn = r0 + rows * rrc;
    push(d, dn,     cont_next ? S(1, 1, 1, 0, 0, 8'd0, 4'd0, 0) : S(0, 1, 0, 0, 0, 8'd0, 4'd0, 0), "frame_done");
    push(d, dn + 1, cont_next ? S(1, 0, 1, 0, 0, 8'd0, 4'd0, 0) : Z, "after_done");
  endtask

  task automatic arm(output int t0);
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic fire(input int d, input logic cont, input logic [9:0] ec);
    continuous    = cont;
    expose_cycles = ec;
    if (d == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t0;

  initial begin
    // Reset held with start asserted: outputs stay 0.
    repeat (2) @(negedge clk);
    start = 1'b1;
    push(0, cyc + 1, Z, "reset_hold");
    push(0, cyc + 2, Z, "reset_hold");
    push(1, cyc + 1, Z, "reset_dut2");
    repeat (2) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;

    // abort + start together in IDLE: stays IDLE.
    arm(t0);
    push(0, t0 + 1, Z, "abort_start_idle");
    push(0, t0 + 3, Z, "abort_start_idle");
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    wait_until(t0 + 5);

    // Single frame.
    arm(t0);
    push_frame(0, t0, 10, 2, 5, 0);
    fire(0, 1'b0, 10'd10);
    wait_until(t0 + 290);

    // Zero exposure treated as one cycle.
    arm(t0);
    push_frame(0, t0, 1, 2, 5, 0);
    fire(0, 1'b0, 10'd0);
    wait_until(t0 + 280);

    // Continuous run, cleared mid-first-frame so it stops after frame two.
    arm(t0);
    push_frame(0, t0, 10, 2, 5, 1);
    push_frame(0, t0 + 281, 10, 2, 5, 0);
    fire(0, 1'b1, 10'd10);
    wait_until(t0 + 200);
    continuous = 1'b0;
    wait_until(t0 + 570);

    // Abort during CONVERT, then a clean frame.
    arm(t0);
    push(0, t0 + 2,   S(1, 0, 1, 0, 0, 8'd0, 4'd0, 0), "erase");
    push(0, t0 + 100, S(1, 0, 0, 0, 1, 8'd84, 4'd0, 0), "ramp_pre_abort");
    push(0, t0 + 101, Z, "abort_idle");
    push(0, t0 + 102, Z, "abort_idle");
    push(0, t0 + 282, Z, "abort_no_done");
    fire(0, 1'b0, 10'd10);
    wait_until(t0 + 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(t0 + 290);
    arm(t0);
    push_frame(0, t0, 10, 2, 5, 0);
    fire(0, 1'b0, 10'd10);
    wait_until(t0 + 290);

    // start re-pulsed while busy is ignored.
    arm(t0);
    push_frame(0, t0, 10, 2, 5, 0);
    push(0, t0 + 51, S(1, 0, 0, 0, 1, 8'd35, 4'd0, 0), "restart_ignored");
    fire(0, 1'b0, 10'd10);
    wait_until(t0 + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 290);

    // reset with abort and start mid-frame.
    arm(t0);
    push(0, t0 + 200, S(1, 0, 0, 0, 1, 8'd184, 4'd0, 0), "ramp_pre_reset");
    push(0, t0 + 201, Z, "reset_idle");
    push(0, t0 + 202, Z, "reset_idle");
    push(0, t0 + 282, Z, "reset_no_done");
    fire(0, 1'b0, 10'd10);
    wait_until(t0 + 200);
    reset = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; abort = 1'b0; start = 1'b0;
    wait_until(t0 + 290);

    // Four rows, three cycles each.
    arm(t0);
    push_frame(1, t0, 10, 4, 3, 0);
    fire(1, 1'b0, 10'd10);
    wait_until(t0 + 290);

    if (q0.size() + q1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_checks: got %0d unconsumed expectations expected 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
